seven_seg_scan_decoder: RTL

- Receive-side counterpart of the multiplexed seven-segment driver.
- Samples the active-low segment, decimal-point and anode scan lines, decodes each segment pattern back to a 4-bit digit, and stores it per digit position.
- Flags completed scan frames and protocol violations.
- Used in loopback self-test and verification of the alarm clock display path, and for mirroring displayed time onto other logic.

---
 rtl/seven_seg_scan_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Receive side of a multiplexed seven-segment display: samples the active-low
// scan lines, decodes each held digit back to a nibble and flags frames and errors.
module seven_seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic                    clk_pi,
    input  logic                    rst_n_pi,
    input  logic [6:0]              seg_pi,
    input  logic                    dp_pi,
    input  logic [NUM_DIGITS-1:0]   an_pi,
    input  logic                    error_clr_pi,
    output logic [4*NUM_DIGITS-1:0] num_po,
    output logic [NUM_DIGITS-1:0]   digit_valid_po,
    output logic [NUM_DIGITS-1:0]   dp_po,
    output logic                    frame_done_po,
    output logic                    error_po,
    output logic [1:0]              error_code_po
);

    localparam int unsigned NUM_W      = 4 * NUM_DIGITS;
    localparam int unsigned STABLE_MIN = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;
    localparam int unsigned CNT_W      = $clog2(STABLE_MIN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_MIN);

    localparam logic [1:0] CODE_SEG   = 2'b01;
    localparam logic [1:0] CODE_MULTI = 2'b10;

    logic [6:0]            seg_s_q, seg_s_d;
    logic                  dp_s_q, dp_s_d;
    logic [NUM_DIGITS-1:0] an_s_q, an_s_d;
    logic [CNT_W-1:0]      dwell_q, dwell_d;
    logic                  fired_q, fired_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [NUM_W-1:0]      num_q, num_d;
    logic [NUM_DIGITS-1:0] valid_q, valid_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;
    logic                  error_q, error_d;
    logic [1:0]            code_q, code_d;

    logic                  same_c;
    logic                  idle_in_c;
    logic                  qual_c;
    logic [NUM_DIGITS-1:0] low_c;
    logic                  multi_c;
    logic                  active_c;
    logic [4:0]            dec_c;
    logic                  legal_c;
    logic [NUM_DIGITS-1:0] mask_set_c;
    logic                  new_err_c;
    logic [1:0]            new_code_c;

    // Returns {legal, value}; blank decodes to F.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        case (seg)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b1111111: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            seg_s_q      <= '1;
            dp_s_q       <= 1'b1;
            an_s_q       <= '1;
            dwell_q      <= '0;
            fired_q      <= 1'b0;
            mask_q       <= '0;
            num_q        <= '1;
            valid_q      <= '0;
            dp_q         <= '0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
            code_q       <= 2'b00;
        end else begin
            seg_s_q      <= seg_s_d;
            dp_s_q       <= dp_s_d;
            an_s_q       <= an_s_d;
            dwell_q      <= dwell_d;
            fired_q      <= fired_d;
            mask_q       <= mask_d;
            num_q        <= num_d;
            valid_q      <= valid_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
            code_q       <= code_d;
        end
    end

    always_comb begin
        seg_s_d      = seg_pi;
        dp_s_d       = dp_pi;
        an_s_d       = an_pi;
        dwell_d      = dwell_q;
        fired_d      = fired_q;
        num_d        = num_q;
        valid_d      = valid_q;
        dp_d         = dp_q;
        error_d      = error_q;
        code_d       = code_q;
        mask_set_c   = '0;

        // dwell_q always describes how long the registered sample has been held
        same_c    = (seg_pi == seg_s_q) && (dp_pi == dp_s_q) && (an_pi == an_s_q);
        idle_in_c = &an_pi;
        if (idle_in_c) begin
            dwell_d = '0;
        end else if (!same_c) begin
            dwell_d = CNT_W'(1);
        end else if (dwell_q < CNT_MAX) begin
            dwell_d = dwell_q + CNT_W'(1);
        end

        low_c    = ~an_s_q;
        multi_c  = (low_c & (low_c - NUM_DIGITS'(1))) != '0;
        active_c = (low_c != '0) && !multi_c;
        qual_c   = (dwell_q == CNT_MAX) && !fired_q;
        dec_c    = seg_decode(seg_s_q);
        legal_c  = dec_c[4];

        fired_d = (idle_in_c || !same_c) ? 1'b0 : (fired_q | qual_c);

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (qual_c && active_c && low_c[i]) begin
                mask_set_c[i] = 1'b1;
                valid_d[i]    = legal_c;
                if (legal_c) begin
                    num_d[i*4 +: 4] = dec_c[3:0];
                    dp_d[i]         = ~dp_s_q;
                end
            end
        end

        // First error wins; a clear coinciding with a new error keeps the new one
        new_err_c  = qual_c && (multi_c || (active_c && !legal_c));
        new_code_c = multi_c ? CODE_MULTI : CODE_SEG;
        if (new_err_c && (!error_q || error_clr_pi)) begin
            error_d = 1'b1;
            code_d  = new_code_c;
        end else if (error_clr_pi) begin
            error_d = 1'b0;
            code_d  = 2'b00;
        end

        frame_done_d = &mask_q;
        mask_d       = ((&mask_q) ? '0 : mask_q) | mask_set_c;
    end

    assign num_po         = num_q;
    assign digit_valid_po = valid_q;
    assign dp_po          = dp_q;
    assign frame_done_po  = frame_done_q;
    assign error_po       = error_q;
    assign error_code_po  = code_q;

endmodule
